// File: rtl/riscv_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface riscv_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/riscv_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
//
// state | meaning
// IDLE  | ready for a request; special cases resolve straight to DONE
// CALC  | WIDTH shift/trial-subtract iterations, MSB first
// FIX   | apply signs and pick quotient or remainder into result
// DONE  | result valid, held until the consumer takes it
module riscv_divider #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    riscv_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] dvd, dsr, rem, quo, result_q;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;

    logic             accept, is_signed, div_zero, overflow;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted;
    logic             ge;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign is_signed = ~bus.op[0];
    assign div_zero  = (bus.divisor == '0);
    assign overflow  = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
    assign abs_a     = (is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign abs_b     = (is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // The shifted remainder keeps its carry-out so the trial compare is WIDTH+1 bits wide;
    // a divisor above 2^(WIDTH-1) would otherwise lose quotient bits.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dsr});

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = (div_zero || overflow) ? DONE : CALC;
            CALC: if (cnt == '0)    state_next = FIX;
            FIX:                    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state only
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.result    = result_q;
    end

    // Datapath: operand capture, shift/subtract iterations and sign fix-up
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= bus.op;
                    dvd    <= abs_a;
                    dsr    <= abs_b;
                    rem    <= '0;
                    quo    <= '0;
                    cnt    <= CW'(WIDTH - 1);
                    sign_q <= is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    sign_r <= is_signed && bus.dividend[WIDTH-1];
                    if (div_zero)      result_q <= bus.op[1] ? bus.dividend : '1;
                    else if (overflow) result_q <= bus.op[1] ? '0 : bus.dividend;
                end
                CALC: begin
                    rem <= ge ? WIDTH'(shifted - {1'b0, dsr}) : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (op_q[1]) result_q <= sign_r ? -rem : rem;
                    else         result_q <= sign_q ? -quo : quo;
                end
                default: ;
            endcase
        end
    end

`ifdef FORMAL
    logic [WIDTH-1:0] orig_q, past_result;
    logic             past_hold;

    // Reference copies for the property checks
    always_ff @(posedge clk) begin
        if (rst) begin
            orig_q      <= '0;
            past_result <= '0;
            past_hold   <= 1'b0;
        end else begin
            if (accept) orig_q <= bus.dividend;
            past_result <= result_q;
            past_hold   <= bus.out_valid && !bus.out_ready;
        end
    end

    // Handshake exclusivity, output stability and DIVU reconstruction
    always_comb begin
        assert (!(bus.in_ready && bus.out_valid));
        if (past_hold) assert (result_q == past_result);
        if (state == FIX && op_q == 2'd1 && dsr != '0)
            assert (({{WIDTH{1'b0}}, quo} * {{WIDTH{1'b0}}, dsr} + {{WIDTH{1'b0}}, rem})
                    == {{WIDTH{1'b0}}, orig_q});
    end
`endif
endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench: directed vector table, backpressure and reset sequences, random ops vs model.
module tb_riscv_divider;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_divider_if #(.WIDTH(W)) bus();
    riscv_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : a;
        if (op[0]) return op[1] ? a % b : a / b;
        return op[1] ? sa % sb : sa / sb;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0 || (!op[0] && a == MIN_NEG && b == '1)) return 1;
        return W + 2;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int cyc);
        int guard;
        guard = 0;
        bus.op = op;
        bus.dividend = a;
        bus.divisor = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = bus.result;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    vec_t         vecs[$];
    logic [W-1:0] res;
    int           cyc;

    initial begin
        vecs.push_back('{2'd1, 32'd100,       32'd7,        32'd14,       34});
        vecs.push_back('{2'd3, 32'd100,       32'd7,        32'd2,        34});
        vecs.push_back('{2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34});
        vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34});
        vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,       34});
        vecs.push_back('{2'd1, 32'd5,         32'd0,        32'hFFFF_FFFF, 1});
        vecs.push_back('{2'd2, MIN_NEG,       32'd0,        MIN_NEG,      1});
        vecs.push_back('{2'd0, MIN_NEG,       32'hFFFF_FFFF, MIN_NEG,     1});
        vecs.push_back('{2'd2, MIN_NEG,       32'hFFFF_FFFF, 32'd0,       1});
        vecs.push_back('{2'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,       34});
        vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34});
        vecs.push_back('{2'd0, MIN_NEG,       32'd2,        32'hC000_0000, 34});

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 2'd0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, cyc);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), W'(cyc), W'(vecs[i].exp_lat));
            check($sformatf("vec%0d_in_ready_after", i), {31'd0, bus.in_ready}, 32'd1);
        end

        // Backpressure: result held, extra requests ignored, in_ready returns after handshake
        bus.op = 2'd1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd10;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.dividend = 32'd77;
        bus.divisor = 32'd3;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", W'(cyc), W'(W + 2));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_result_%0d", k), bus.result, 32'd100);
            check($sformatf("bp_in_ready_%0d", k), {31'd0, bus.in_ready}, 32'd0);
            check($sformatf("bp_out_valid_%0d", k), {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("bp_out_valid_after", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a calculation discards it
        bus.op = 2'd1;
        bus.dividend = 32'h0000_FFFF;
        bus.divisor = 32'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        run_op(2'd1, 32'd9, 32'd3, res, cyc);
        check("post_rst_result", res, 32'd3);
        check("post_rst_latency", W'(cyc), W'(W + 2));

        // Random operations against the arithmetic model
        for (int n = 0; n < 200; n++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = MIN_NEG; rb = '1; end
                3: rb = -W'($urandom_range(1, 15));
                4: ra = W'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(rop, ra, rb, res, cyc);
            check($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb), res, ref_model(rop, ra, rb));
            check($sformatf("rand%0d_latency", n), W'(cyc), W'(ref_lat(rop, ra, rb)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
